e_mem_loader: RTL and testbench

E_MEM_LOADER -- requirements
Module: e_mem_loader

---
 rtl/e_mem_loader_pkg.sv | 36 +++
 rtl/e_mem_port_mux.sv | 23 ++
 rtl/e_mem_loader.sv | 139 +++++++++++++
 tb/tb_e_mem_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/e_mem_loader_pkg.sv
// rtl/e_mem_loader_pkg.sv - shared state encoding, size defaults and clog2 helper (feature macro: LOADER_ZEROIZE_EN)
`ifndef M
`define M 8
`endif
`ifndef R
`define R 4
`endif

package e_mem_loader_pkg;

`ifdef LOADER_ZEROIZE_EN
  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_HASH,
    ST_HOLD,
    ST_ZERO
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_HASH,
    ST_HOLD
  } state_e;
`endif

  // Address width for a RAM of 'value' words; never returns less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/e_mem_port_mux.sv
// rtl/e_mem_port_mux.sv - RAM port select between the loader write side and the hasher read address
module e_mem_port_mux #(
  parameter int AW    = 2,
  parameter int WIDTH = 8
) (
  input  logic             sel_hash_i,
  input  logic             ld_we_i,
  input  logic [AW-1:0]    ld_addr_i,
  input  logic [WIDTH-1:0] ld_din_i,
  input  logic [AW-1:0]    hash_addr_i,
  output logic             ram_we_o,
  output logic [AW-1:0]    ram_addr_o,
  output logic [WIDTH-1:0] ram_din_o
);

  // Hasher owns the address while selected and never writes.
  always_comb begin
    ram_we_o   = sel_hash_i ? 1'b0 : ld_we_i;
    ram_addr_o = sel_hash_i ? hash_addr_i : ld_addr_i;
    ram_din_o  = ld_din_i;
  end

endmodule

// File: rtl/e_mem_loader.sv
// rtl/e_mem_loader.sv - message loader: fills RAM, kicks the hasher, holds the digest until acked (feature macro: LOADER_ZEROIZE_EN)
module e_mem_loader
  import e_mem_loader_pkg::*;
#(
  parameter int m     = `M,
  parameter int r     = `R,
  parameter int digit = 1,
  localparam int WIDTH = m * digit,
  localparam int DEPTH = (r + digit - 1) / digit,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [AW-1:0]    hash_mem_addr,
  output logic             hash_in_ready,
  input  logic             hash_out_ready,
  input  logic [63:0]      hash_out_usr,
  output logic [63:0]      key,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             busy
);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [63:0]     key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic            ld_we;
  logic [AW-1:0]   ld_addr;
  logic [WIDTH-1:0] ld_din;
  logic            sel_hash;
  logic            cnt_last;

  // wr_cnt doubles as the clear pointer in ZERO; both passes end on the last word.
  assign cnt_last = (wr_cnt_q == AW'(DEPTH - 1));

  // Next-state and loader-side port control; reset forces the idle-load face on outputs.
  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    key_d         = key_q;
    key_valid_d   = key_valid_q;
    s_ready       = 1'b0;
    ld_we         = 1'b0;
    ld_addr       = '0;
    ld_din        = '0;
    sel_hash      = 1'b0;
    hash_in_ready = 1'b0;
    case (state_q)
      ST_LOAD: begin
        s_ready = 1'b1;
        ld_addr = wr_cnt_q;
        ld_din  = s_data;
        if (s_valid) begin
          ld_we    = 1'b1;
          wr_cnt_d = cnt_last ? '0 : wr_cnt_q + AW'(1);
          if (cnt_last) state_d = ST_START;
        end
      end
      ST_START: begin
        sel_hash      = 1'b1;
        hash_in_ready = 1'b1;
        state_d       = ST_HASH;
      end
      ST_HASH: begin
        sel_hash = 1'b1;
        if (hash_out_ready) begin
          key_d       = hash_out_usr;
          key_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (key_ack && key_valid_q) begin
          key_valid_d = 1'b0;
`ifdef LOADER_ZEROIZE_EN
          state_d     = ST_ZERO;
`else
          state_d     = ST_LOAD;
`endif
        end
      end
`ifdef LOADER_ZEROIZE_EN
      ST_ZERO: begin
        ld_we    = 1'b1;
        ld_addr  = wr_cnt_q;
        wr_cnt_d = cnt_last ? '0 : wr_cnt_q + AW'(1);
        if (cnt_last) state_d = ST_LOAD;
      end
`endif
      default: state_d = ST_LOAD;
    endcase
    if (!rst_b) begin
      s_ready       = 1'b1;
      ld_we         = 1'b0;
      hash_in_ready = 1'b0;
    end
  end

  assign busy      = rst_b && (state_q != ST_LOAD);
  assign key       = key_q;
  assign key_valid = key_valid_q;

  // State, counter and captured digest registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= ST_LOAD;
      wr_cnt_q    <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  e_mem_port_mux #(
    .AW    (AW),
    .WIDTH (WIDTH)
  ) u_port_mux (
    .sel_hash_i  (sel_hash),
    .ld_we_i     (ld_we),
    .ld_addr_i   (ld_addr),
    .ld_din_i    (ld_din),
    .hash_addr_i (hash_mem_addr),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_din_o   (ram_din)
  );

endmodule

// File: tb/tb_e_mem_loader.sv
// tb/tb_e_mem_loader.sv - table vectors, corner sequences and randomized episodes for e_mem_loader
module tb_e_mem_loader;

  localparam int D = 4;
  localparam logic [63:0] K1 = 64'hDEAD_BEEF_00C0_FFEE;
  localparam logic [63:0] K2 = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic        ram_we;
  logic [1:0]  ram_addr;
  logic [7:0]  ram_din;
  logic [1:0]  hash_mem_addr = '0;
  logic        hash_in_ready;
  logic        hash_out_ready = 1'b0;
  logic [63:0] hash_out_usr = '0;
  logic [63:0] key;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  e_mem_loader #(.m(8), .r(4), .digit(1)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .hash_mem_addr  (hash_mem_addr),
    .hash_in_ready  (hash_in_ready),
    .hash_out_ready (hash_out_ready),
    .hash_out_usr   (hash_out_usr),
    .key            (key),
    .key_valid      (key_valid),
    .key_ack        (key_ack),
    .busy           (busy)
  );

  typedef struct {
    logic        rst_b, sv;
    logic [7:0]  data;
    logic [1:0]  hma;
    logic        hor;
    logic [63:0] usr;
    logic        ack;
    logic        e_sr, e_we;
    logic [1:0]  e_addr;
    logic [7:0]  e_din;
    logic        e_hin, e_busy, e_kv;
    logic [63:0] e_key;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rb, input logic sv, input logic [7:0] d, input logic [1:0] a,
                              input logic ho, input logic [63:0] u, input logic ak,
                              input logic sr, input logic we, input logic [1:0] ea, input logic [7:0] ed,
                              input logic hin, input logic bz, input logic kv, input logic [63:0] ek);
    vec_t v;
    v.rst_b = rb; v.sv = sv; v.data = d; v.hma = a; v.hor = ho; v.usr = u; v.ack = ak;
    v.e_sr = sr; v.e_we = we; v.e_addr = ea; v.e_din = ed; v.e_hin = hin; v.e_busy = bz; v.e_kv = kv; v.e_key = ek;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [7:0] d, input logic [1:0] a,
                       input logic ho, input logic [63:0] u, input logic ak);
    s_valid = sv; s_data = d; hash_mem_addr = a; hash_out_ready = ho; hash_out_usr = u; key_ack = ak;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic reset_cycle();
    rst_b = 1'b0;
    drive(1'b1, 8'($urandom), 2'($urandom), 1'b1, rnd64(), 1'b1);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_we", ram_we, 0);
    chk("rst_start", hash_in_ready, 0);
    chk("rst_busy", busy, 0);
    adv();
    rst_b = 1'b1;
  endtask

  // One full message: load D words, start, hash latency, digest, ack wait, optional clear.
  task automatic run_episode(input int mode, input int hor_len, input int ack_dly);
    logic [7:0]  w [D];
    logic [63:0] k;
    logic [1:0]  hma;
    logic        sv;
    int          idx, cyc, lat;
    foreach (w[i]) w[i] = 8'($urandom);
    k   = rnd64();
    idx = 0;
    cyc = 0;
    while (idx < D && cyc < 200) begin
      case (mode)
        0:       sv = 1'b1;
        1:       sv = (cyc % 2 == 0);
        default: sv = ($urandom_range(0, 2) == 0);
      endcase
      drive(sv, sv ? w[idx] : 8'($urandom), 2'($urandom), 1'($urandom), rnd64(), 1'($urandom));
      chk("load_s_ready", s_ready, 1);
      chk("load_busy", busy, 0);
      chk("load_start", hash_in_ready, 0);
      chk("load_key_valid", key_valid, 0);
      chk("load_we", ram_we, sv);
      if (sv) begin
        chk("load_addr", ram_addr, idx);
        chk("load_din", ram_din, w[idx]);
      end
      adv();
      if (sv) idx++;
      cyc++;
    end
    if (idx < D) begin
      chk("load_timeout", idx, D);
      return;
    end
    hma = 2'($urandom);
    drive(1'b1, 8'($urandom), hma, 1'b0, rnd64(), 1'b0);
    chk("start_pulse", hash_in_ready, 1);
    chk("start_s_ready", s_ready, 0);
    chk("start_we", ram_we, 0);
    chk("start_addr", ram_addr, hma);
    chk("start_busy", busy, 1);
    adv();
    lat = $urandom_range(0, 4);
    repeat (lat) begin
      hma = 2'($urandom);
      drive(1'($urandom), 8'($urandom), hma, 1'b0, rnd64(), 1'($urandom));
      chk("hash_start", hash_in_ready, 0);
      chk("hash_s_ready", s_ready, 0);
      chk("hash_we", ram_we, 0);
      chk("hash_addr", ram_addr, hma);
      chk("hash_key_valid", key_valid, 0);
      adv();
    end
    for (int i = 0; i < hor_len; i++) begin
      drive(1'($urandom), 8'($urandom), 2'($urandom), 1'b1, (i == 0) ? k : rnd64(), 1'b0);
      if (i == 0) begin
        chk("capture_key_valid", key_valid, 0);
      end else begin
        chk("hold_key_valid", key_valid, 1);
        chk("hold_key", key, k);
        chk("hold_addr", ram_addr, 0);
      end
      chk("digest_start", hash_in_ready, 0);
      adv();
    end
    repeat (ack_dly) begin
      drive(1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), rnd64(), 1'b0);
      chk("wait_key_valid", key_valid, 1);
      chk("wait_key", key, k);
      chk("wait_s_ready", s_ready, 0);
      chk("wait_busy", busy, 1);
      chk("wait_we", ram_we, 0);
      chk("wait_addr", ram_addr, 0);
      adv();
    end
    drive(1'($urandom), 8'($urandom), 2'($urandom), 1'b0, rnd64(), 1'b1);
    chk("ack_key_valid", key_valid, 1);
    chk("ack_key", key, k);
    adv();
`ifdef LOADER_ZEROIZE_EN
    for (int i = 0; i < D; i++) begin
      drive(1'b1, 8'($urandom), 2'($urandom), 1'b0, rnd64(), 1'b0);
      chk("zero_we", ram_we, 1);
      chk("zero_addr", ram_addr, i);
      chk("zero_din", ram_din, 0);
      chk("zero_s_ready", s_ready, 0);
      chk("zero_key_valid", key_valid, 0);
      adv();
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back(mk(0,1,8'h99,0,0,0,0,  1,0,0,8'h00,0,0,0,0));
    tbl.push_back(mk(1,1,8'h11,0,0,0,0,  1,1,0,8'h11,0,0,0,0));
    tbl.push_back(mk(1,1,8'h22,0,0,0,0,  1,1,1,8'h22,0,0,0,0));
    tbl.push_back(mk(1,1,8'h33,0,0,0,0,  1,1,2,8'h33,0,0,0,0));
    tbl.push_back(mk(1,1,8'h44,0,0,0,0,  1,1,3,8'h44,0,0,0,0));
    tbl.push_back(mk(1,1,8'h55,2,0,0,0,  0,0,2,8'h00,1,1,0,0));
    tbl.push_back(mk(1,1,8'h66,1,0,0,0,  0,0,1,8'h00,0,1,0,0));
    tbl.push_back(mk(1,0,8'h00,3,1,K1,0, 0,0,3,8'h00,0,1,0,0));
    tbl.push_back(mk(1,0,8'h00,3,1,K1,0, 0,0,0,8'h00,0,1,1,K1));
    tbl.push_back(mk(1,0,8'h00,1,1,K1,0, 0,0,0,8'h00,0,1,1,K1));
    tbl.push_back(mk(1,0,8'h00,1,1,K1,0, 0,0,0,8'h00,0,1,1,K1));
    tbl.push_back(mk(1,0,8'h00,1,1,K1,0, 0,0,0,8'h00,0,1,1,K1));
    tbl.push_back(mk(1,1,8'h00,2,1,K2,0, 0,0,0,8'h00,0,1,1,K1));
    tbl.push_back(mk(1,0,8'h00,2,0,K2,0, 0,0,0,8'h00,0,1,1,K1));
    tbl.push_back(mk(1,0,8'h00,2,0,K2,1, 0,0,0,8'h00,0,1,1,K1));
`ifdef LOADER_ZEROIZE_EN
    for (int i = 0; i < D; i++)
      tbl.push_back(mk(1,1,8'hA5,0,0,0,0, 0,1,2'(i),8'h00,0,1,0,K1));
`else
    tbl.push_back(mk(1,0,8'h00,0,0,0,0,  1,0,0,8'h00,0,0,0,K1));
`endif
    tbl.push_back(mk(1,1,8'h77,0,0,0,1,  1,1,0,8'h77,0,0,0,K1));

    foreach (tbl[i]) begin
      rst_b = tbl[i].rst_b;
      drive(tbl[i].sv, tbl[i].data, tbl[i].hma, tbl[i].hor, tbl[i].usr, tbl[i].ack);
      chk($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].e_sr);
      chk($sformatf("vec%0d_we", i), ram_we, tbl[i].e_we);
      chk($sformatf("vec%0d_addr", i), ram_addr, tbl[i].e_addr);
      if (tbl[i].e_we) chk($sformatf("vec%0d_din", i), ram_din, tbl[i].e_din);
      chk($sformatf("vec%0d_start", i), hash_in_ready, tbl[i].e_hin);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_key_valid", i), key_valid, tbl[i].e_kv);
      chk($sformatf("vec%0d_key", i), key, tbl[i].e_key);
      adv();
    end
    rst_b = 1'b1;

    reset_cycle();
    drive(1'b1, 8'hA1, 0, 1'b0, 0, 1'b0); adv();
    drive(1'b1, 8'hA2, 0, 1'b0, 0, 1'b0); adv();
    reset_cycle();
    run_episode(0, 5, 10);
    run_episode(1, 2, 0);

    for (int i = 0; i < D; i++) begin
      drive(1'b1, 8'($urandom), 0, 1'b0, 0, 1'b0);
      adv();
    end
    reset_cycle();
    run_episode(0, 1, 3);

    for (int e = 0; e < 20; e++)
      run_episode($urandom_range(0, 2), $urandom_range(1, 4), $urandom_range(0, 6));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
